// File: rtl/fir_pkg.sv
// Shared FIR constants, coefficient type and loader state encoding.
// The FIR datapath and its benches import the same definitions.
package fir_pkg;

  localparam int NTAPS = 123;
  localparam int CW    = 17;
  localparam int IDXW  = $clog2(NTAPS + 1);

  typedef logic signed [CW-1:0] coeff_t;
  typedef logic [IDXW-1:0]      idx_t;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LOAD      = 2'd1,
    ST_WAIT_SWAP = 2'd2
  } load_state_e;

  // True when idx addresses the final tap of a set.
  function automatic logic is_last_tap(input idx_t idx);
    return (idx == idx_t'(NTAPS - 1));
  endfunction

endpackage

// File: rtl/fir_coeff_loader_if.sv
// Coefficient beat stream (valid/ready with end-of-set marker) from the
// coefficient source into the loader.
interface fir_coeff_loader_if;
  import fir_pkg::*;

  logic   c_valid;
  coeff_t c_data;
  logic   c_last;
  logic   c_ready;

  modport master (output c_valid, output c_data, output c_last, input c_ready);
  modport slave  (input c_valid, input c_data, input c_last, output c_ready);

endinterface

// File: rtl/fir_coeff_shadow.sv
// Shadow coefficient bank: one indexed write port, full-width flat read-out.
// Contents carry no reset; a set is only trusted once fully written.
module fir_coeff_shadow
  import fir_pkg::*;
(
  input  logic                clk,
  input  logic                we,
  input  idx_t                idx,
  input  coeff_t              data,
  output logic [NTAPS*CW-1:0] rd_flat
);

  coeff_t mem_r [NTAPS];

  // Indexed tap write; out-of-range indices are dropped.
  always_ff @(posedge clk) begin
    if (we && (idx < idx_t'(NTAPS))) begin
      mem_r[idx] <= data;
    end
  end

  // Flatten taps so tap k lands at bits [k*CW +: CW].
  always_comb begin
    rd_flat = '0;
    for (int k = 0; k < NTAPS; k++) begin
      rd_flat[k*CW +: CW] = mem_r[k];
    end
  end

endmodule

// File: rtl/fir_coeff_loader.sv
// Streams coefficients into a shadow bank and commits the full set to the
// active bank only on a sample-boundary strobe.
module fir_coeff_loader
  import fir_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 load_start,
  fir_coeff_loader_if.slave    cif,
  input  logic                 swap_en,
  output logic [NTAPS*CW-1:0]  h_flat,
  output logic                 bank_id,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  load_state_e         state_r, state_s;
  idx_t                idx_r, idx_s;
  logic                accept_s;
  logic                commit_s;
  logic                err_set_s;
  logic [NTAPS*CW-1:0] shadow_flat_s;
  logic [NTAPS*CW-1:0] h_flat_r;
  logic                bank_id_r;
  logic                done_r;
  logic                err_r;

  // load_start masks ready so a restart cycle never also writes a tap.
  assign cif.c_ready = (state_r == ST_LOAD) & ~load_start;
  assign accept_s    = cif.c_valid & cif.c_ready;

  // Next-state, tap index and commit/error decode.
  always_comb begin
    state_s   = state_r;
    idx_s     = idx_r;
    commit_s  = 1'b0;
    err_set_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (load_start) begin
          state_s = ST_LOAD;
          idx_s   = '0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (load_start) begin
          state_s = ST_LOAD;
          idx_s   = '0;
        end else if (accept_s) begin
          if (is_last_tap(idx_r)) begin
            idx_s = '0;
            if (cif.c_last) begin
              state_s = ST_WAIT_SWAP;
            end else begin
              state_s   = ST_IDLE;
              err_set_s = 1'b1;
            end
          end else if (cif.c_last) begin
            state_s   = ST_IDLE;
            idx_s     = '0;
            err_set_s = 1'b1;
          end else begin
            idx_s = idx_r + idx_t'(1);
          end
        end else begin
          state_s = ST_LOAD;
        end
      end
      ST_WAIT_SWAP: begin
        if (load_start) begin
          state_s = ST_LOAD;
          idx_s   = '0;
        end else if (swap_en) begin
          state_s  = ST_IDLE;
          commit_s = 1'b1;
        end else begin
          state_s = ST_WAIT_SWAP;
        end
      end
      default: begin
        state_s = ST_IDLE;
        idx_s   = '0;
      end
    endcase
  end

  // State and tap index registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
      idx_r   <= '0;
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
    end
  end

  fir_coeff_shadow u_shadow (
    .clk     (clk),
    .we      (accept_s),
    .idx     (idx_r),
    .data    (cif.c_data),
    .rd_flat (shadow_flat_s)
  );

  // Active bank: every tap loads on the same edge so the filter never sees a mix.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_flat_r  <= '0;
      bank_id_r <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      done_r <= commit_s;
      if (commit_s) begin
        h_flat_r  <= shadow_flat_s;
        bank_id_r <= ~bank_id_r;
      end
    end
  end

  // Sticky length-mismatch flag, cleared only by a new load.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_r <= 1'b0;
    end else if (load_start) begin
      err_r <= 1'b0;
    end else if (err_set_s) begin
      err_r <= 1'b1;
    end
  end

  assign h_flat  = h_flat_r;
  assign bank_id = bank_id_r;
  assign done    = done_r;
  assign err     = err_r;
  assign busy    = (state_r != ST_IDLE);

endmodule

// File: doc/fir_coeff_loader.md
# fir_coeff_loader

Streams FIR tap coefficients one per handshake into a shadow register bank and commits the full set to the active bank driving the filter's parallel coefficient input. The commit happens only on a sample-boundary strobe, so a running filter never sees a half-updated tap set. It sits between the host/coefficient source and the FIR datapath. It is the writer for the filter's coefficient bus, which the filter reads every cycle.

## Interface
- NTAPS, 123, number of taps.
- CW, 17, coefficient width, signed two's complement.
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- load_start  in  1  one-cycle pulse that begins a new load, or restarts one in progress.
- c_valid  in  1  coefficient beat valid.
- c_data  in  CW  coefficient value.
- c_last  in  1  marks the final beat of a set; qualified by c_valid.
- c_ready  out  1  loader accepts a beat this cycle.
- swap_en  in  1  sample-boundary strobe; commit is permitted only while it is high.
- h_flat  out  NTAPS*CW  active coefficients; tap k occupies bits [k*CW +: CW].
- bank_id  out  1  toggles on every commit.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse, aligned with the new h_flat.
- err  out  1  sticky length-mismatch flag.

## Operation
- States: IDLE, LOAD, WAIT_SWAP.
- Beat acceptance: a beat is accepted when c_valid & c_ready.
- c_ready rule: c_ready = (state==LOAD) & ~load_start.
  - It is combinational from state and load_start only.
  - It never depends on c_valid.
- IDLE:
  - c_ready=0.
  - load_start → LOAD, idx=0, err cleared.
- LOAD, on each accepted beat:
  - shadow[idx] ← c_data, idx ← idx+1.
  - The first beat is tap 0 (the tap applied to the newest sample).
- LOAD, end-of-set outcomes:
  - Accepted beat with c_last=1 and idx==NTAPS-1 → WAIT_SWAP.
  - Accepted beat with c_last=1 and idx<NTAPS-1 (set too short) → IDLE, err=1.
  - Accepted beat with c_last=0 and idx==NTAPS-1 (set too long) → IDLE, err=1.
  - On either error, the shadow contents are abandoned and h_flat is untouched.
- WAIT_SWAP:
  - c_ready=0.
  - swap_en=1 → h_flat ← shadow (all taps on the same edge), bank_id toggles, done=1 next cycle, → IDLE.
- load_start in LOAD or WAIT_SWAP:
  - Restarts at LOAD with idx=0 and err cleared.
  - Any pending set is discarded without committing.
  - load_start takes priority over swap_en in the same cycle.
- No arithmetic is performed: coefficients are stored bit-exact and never sign-extended or rounded.
- Reset (asynchronous, any state):
  - Returns to IDLE with idx=0.
  - h_flat=0, bank_id=0, c_ready=0, busy=0, done=0, err=0.
  - Shadow contents are don't-care.

## Timing
- Minimum load: NTAPS accepted beats (one per cycle at full rate), then one or more cycles in WAIT_SWAP.
- Commit edge: the first edge with state==WAIT_SWAP & swap_en=1.
  - h_flat, bank_id and done all change at that edge.
  - The filter sees the new taps from the following cycle.
- busy:
  - Rises the cycle after load_start.
  - Falls together with done, or the cycle after an error beat.
- done is high exactly one cycle per commit; there is never more than one commit per load_start.
- err sets on the edge that accepts the offending beat and holds until the next load_start or reset.
- Back-pressure on the source only in IDLE/WAIT_SWAP; LOAD never stalls.

## Structure
- Shared package fir_pkg holds:
  - NTAPS and CW defaults.
  - The coefficient typedef (signed [CW-1:0]).
  - The loader state enum.
- These are the same constants the FIR datapath and its benches use.
- One sub-module, fir_coeff_shadow:
  - NTAPS×CW register array with an indexed write port (we, idx, data).
  - Flat read-out port.
  - Instantiated once as the shadow bank.
- The active bank is a plain flop bank in the top, loaded in parallel on the commit edge.

## Test plan
- Reset then idle: deassert reset_n with no stimulus → h_flat=0, bank_id=0, c_ready=0, busy=0 for 20 cycles.
- Full load at full rate:
  - Stimulus: load_start, then 123 back-to-back beats c_data=k+1 with c_last on beat 122, swap_en pulsed 5 cycles later.
  - Required: h_flat[k*17 +: 17]==k+1 for all k, bank_id=1, and a single-cycle done on the commit edge.
- Delayed swap and gapped valid:
  - Stimulus: 123 beats with random c_valid gaps, then swap_en held low for 50 cycles.
  - Required: h_flat unchanged while in WAIT_SWAP, c_ready=0 throughout WAIT_SWAP, commit on the first swap_en.
- Short and long sets:
  - Stimulus: c_last on beat 60, then a separate load with no c_last by beat 122.
  - Required: err=1 after each, h_flat keeps the previous set, bank_id unchanged, no done.
- Restart:
  - Stimulus: load_start issued mid-LOAD at idx=40 and again in WAIT_SWAP together with swap_en.
  - Required: no commit, idx restarts at 0, c_ready=0 on the load_start cycle, err cleared.
- Async reset mid-load:
  - Stimulus: pull reset_n low at idx=70, then release and perform a full load of value 17'h1FFFF.
  - Required: outputs return to reset values immediately, and h_flat==all taps 17'h1FFFF after commit (bit-exact negative value).
